register_bank: RTL and testbench



---
 rtl/rf_pkg.sv | 7 +
 rtl/register_bank_if.sv | 23 ++
 rtl/rf_read_port.sv | 29 ++
 rtl/register_bank.sv | 34 +++
 tb/tb_register_bank.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and types for the register bank and its read ports.
package rf_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;
    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
endpackage

// File: rtl/register_bank_if.sv
// register_bank_if: read/writeback bus between the datapath and the register bank.
interface register_bank_if #(
    parameter int DATA_W = rf_pkg::RF_DATA_W,
    parameter int ADDR_W = rf_pkg::RF_ADDR_W
);
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rd_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    modport master (
        output rd_en, rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        input  rs_data, rt_data, rd_valid
    );
    modport slave (
        input  rd_en, rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        output rs_data, rt_data, rd_valid
    );
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port with zero-register and write-first bypass selection.
module rf_read_port #(
    parameter int DATA_W   = rf_pkg::RF_DATA_W,
    parameter int ADDR_W   = rf_pkg::RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);
    logic [DATA_W-1:0] sel;

    // zero register beats bypass, bypass beats the pre-edge storage value
    always_comb
        sel = (ZERO_REG != 0 && addr == '0) ? '0 :
              (wr_en && wr_addr == addr)    ? wr_data : regs[addr];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            data <= '0;
        else if (rd_en)
            data <= sel;
endmodule

// File: rtl/register_bank.sv
// register_bank: 2**ADDR_W x DATA_W architectural register file, two registered
// read ports with same-cycle write bypass and one writeback port.
module register_bank #(
    parameter int DATA_W   = rf_pkg::RF_DATA_W,
    parameter int ADDR_W   = rf_pkg::RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input logic            clk,
    input logic            rst_n,
    register_bank_if.slave bus
);
    logic [DATA_W-1:0] regs [2**ADDR_W];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++)
                regs[i] <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            if (bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0))
                regs[bus.wr_addr] <= bus.wr_data;
            bus.rd_valid <= bus.rd_en;
        end

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rs (
        .clk(clk), .rst_n(rst_n), .rd_en(bus.rd_en), .addr(bus.rs_addr), .regs(regs),
        .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data), .data(bus.rs_data)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rt (
        .clk(clk), .rst_n(rst_n), .rd_en(bus.rd_en), .addr(bus.rt_addr), .regs(regs),
        .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data), .data(bus.rt_data)
    );
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed table, corner sequences and randomized traffic against a register-file model.
module tb_register_bank;
    import rf_pkg::*;

    typedef struct {
        logic     rd;
        rf_addr_t rs;
        rf_addr_t rt;
        logic     wr;
        rf_addr_t wa;
        rf_data_t wd;
        rf_data_t ers;
        rf_data_t ert;
        logic     ev;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    rf_data_t mem [16];
    rf_data_t e_rs, e_rt;
    logic e_v;

    register_bank_if bus ();
    register_bank dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input rf_data_t act, input rf_data_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " rs_data"}, bus.rs_data, e_rs);
        check({tag, " rt_data"}, bus.rt_data, e_rt);
        check({tag, " rd_valid"}, {31'd0, bus.rd_valid}, {31'd0, e_v});
    endtask

    function automatic rf_data_t model_read(input rf_addr_t a, input logic wr,
                                            input rf_addr_t wa, input rf_data_t wd);
        if (a == 0) return '0;
        if (wr && wa == a) return wd;
        return mem[a];
    endfunction

    task automatic model_reset();
        foreach (mem[i]) mem[i] = '0;
        e_rs = '0;
        e_rt = '0;
        e_v = 1'b0;
    endtask

    // drive one cycle from a negedge, update the model, return at the next negedge
    task automatic cycle(input logic rd, input rf_addr_t rs, input rf_addr_t rt,
                         input logic wr, input rf_addr_t wa, input rf_data_t wd);
        bus.rd_en = rd; bus.rs_addr = rs; bus.rt_addr = rt;
        bus.wr_en = wr; bus.wr_addr = wa; bus.wr_data = wd;
        if (rd) begin
            e_rs = model_read(rs, wr, wa, wd);
            e_rt = model_read(rt, wr, wa, wd);
        end
        e_v = rd;
        if (wr && wa != 0) mem[wa] = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h0, 32'h0, 0};
        tbl[1]  = '{0, 0, 0, 1, 9, 32'h0F0F0F0F, 32'h0, 32'h0, 0};
        tbl[2]  = '{1, 5, 9, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0F0F0F0F, 1};
        tbl[3]  = '{1, 5, 9, 1, 3, 32'h11111111, 32'hDEADBEEF, 32'h0F0F0F0F, 1};
        tbl[4]  = '{1, 3, 3, 1, 3, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1};
        tbl[5]  = '{1, 3, 9, 0, 0, 32'h0, 32'hCAFEF00D, 32'h0F0F0F0F, 1};
        tbl[6]  = '{1, 0, 0, 1, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 1};
        tbl[7]  = '{1, 0, 3, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D, 1};
        tbl[8]  = '{1, 5, 5, 0, 0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1};
        tbl[9]  = '{0, 0, 0, 1, 5, 32'h1, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        tbl[10] = '{0, 0, 0, 1, 5, 32'h1, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        tbl[11] = '{0, 0, 0, 1, 5, 32'h1, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        tbl[12] = '{1, 5, 9, 0, 0, 32'h0, 32'h00000001, 32'h0F0F0F0F, 1};

        model_reset();
        bus.rd_en = 0; bus.rs_addr = 0; bus.rt_addr = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;

        // reads and writes issued while reset is held must have no effect
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            bus.rd_en = 1; bus.rs_addr = rf_addr_t'(i); bus.rt_addr = rf_addr_t'(15 - i);
            bus.wr_en = 1; bus.wr_addr = rf_addr_t'(i); bus.wr_data = 32'hFFFF0000 | i;
            @(negedge clk);
            check_all("in_reset");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle(1, rf_addr_t'(i), rf_addr_t'(i), 0, 0, 0);
            check_all("after_reset");
        end
        cycle(0, 0, 0, 0, 0, 0);
        check_all("idle");

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].wr, tbl[i].wa, tbl[i].wd);
            check($sformatf("tbl%0d rs_data", i), bus.rs_data, tbl[i].ers);
            check($sformatf("tbl%0d rt_data", i), bus.rt_data, tbl[i].ert);
            check($sformatf("tbl%0d rd_valid", i), {31'd0, bus.rd_valid}, {31'd0, tbl[i].ev});
        end

        for (int i = 0; i < 400; i++) begin
            logic wide;
            rf_addr_t rs, rt, wa;
            wide = ($urandom_range(0, 3) != 0);
            rs = rf_addr_t'(wide ? $urandom_range(0, 15) : $urandom_range(0, 3));
            rt = rf_addr_t'(wide ? $urandom_range(0, 15) : $urandom_range(0, 3));
            wa = rf_addr_t'(wide ? $urandom_range(0, 15) : $urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), rs, rt, 1'($urandom_range(0, 1)), wa, $urandom);
            check_all("rand");
        end

        // asynchronous reset landing between a read edge and the next edge
        cycle(0, 0, 0, 1, 5, 32'hA5A5A5A5);
        bus.rd_en = 1; bus.rs_addr = 5; bus.rt_addr = 5; bus.wr_en = 0;
        e_rs = mem[5]; e_rt = mem[5]; e_v = 1;
        @(posedge clk);
        #2;
        check_all("pre_mid_reset");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle(1, rf_addr_t'(i), rf_addr_t'(15 - i), 0, 0, 0);
            check_all("post_mid_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
